// File: rtl/clock_ctrl.sv
// Timekeeping and time-setting controller: 1 s tick divider, BCD h/m/s
// counters, a four-state set-mode FSM driven by two debounced keys,
// a per-field blink mask for the field being set and an hourly chime.
module clock_ctrl #(
  parameter int CLK_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [1:0] mode,
  output logic [2:0] blink,
  output logic       tick,
  output logic       chime
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } mode_t;

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  // One BCD step with wrap to 00 after the field's last legal value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [7:0]    hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  mode_t         mode_q, mode_d;
  logic [2:0]    blink_q, blink_d;
  logic          tick_q, tick_d, chime_q, chime_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          prev_mode_q, prev_mode_d, prev_inc_q, prev_inc_d;
  logic          mode_edge, inc_edge, div_last;

  // Next-state: divider, time advance, mode FSM, key increments and blink.
  always_comb begin
    hour_d      = hour_q;
    minute_d    = minute_q;
    second_d    = second_q;
    mode_d      = mode_q;
    chime_d     = 1'b0;
    prev_mode_d = key_mode;
    prev_inc_d  = key_inc;
    mode_edge   = key_mode & ~prev_mode_q;
    inc_edge    = key_inc & ~prev_inc_q;

    div_last = (div_q == DIV_LAST);
    tick_d   = div_last;
    div_d    = div_last ? '0 : div_q + DW'(1);

    if (mode_q == RUN && div_last) begin
      second_d = bcd_inc(second_q, 8'h59);
      if (second_q == 8'h59) begin
        minute_d = bcd_inc(minute_q, 8'h59);
        if (minute_q == 8'h59) begin
          hour_d  = bcd_inc(hour_q, 8'h23);
          chime_d = 1'b1;
        end
      end
    end

    if (bcnt_q == BLK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
    end

    // A mode edge takes priority; a coincident increment is dropped.
    if (mode_edge) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        default: begin
          mode_d = RUN;
          div_d  = '0;
        end
      endcase
      if (mode_d != RUN) begin
        bcnt_d  = '0;
        phase_d = 1'b0;
      end
    end else if (inc_edge && mode_q != RUN) begin
      case (mode_q)
        SET_H:   hour_d   = bcd_inc(hour_q, 8'h23);
        SET_M:   minute_d = bcd_inc(minute_q, 8'h59);
        default: second_d = bcd_inc(second_q, 8'h59);
      endcase
      bcnt_d  = '0;
      phase_d = 1'b0;
    end

    case (mode_d)
      SET_H:   blink_d = {phase_d, 2'b00};
      SET_M:   blink_d = {1'b0, phase_d, 1'b0};
      SET_S:   blink_d = {2'b00, phase_d};
      default: blink_d = 3'b000;
    endcase
  end

  // State register with synchronous reset; key history tracks live levels.
  always_ff @(posedge CP) begin
    if (CR) begin
      hour_q      <= 8'h00;
      minute_q    <= 8'h00;
      second_q    <= 8'h00;
      mode_q      <= RUN;
      blink_q     <= 3'b000;
      tick_q      <= 1'b0;
      chime_q     <= 1'b0;
      div_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      prev_mode_q <= key_mode;
      prev_inc_q  <= key_inc;
    end else begin
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      mode_q      <= mode_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      chime_q     <= chime_d;
      div_q       <= div_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      prev_mode_q <= prev_mode_d;
      prev_inc_q  <= prev_inc_d;
    end
  end

  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;
  assign mode   = mode_q;
  assign blink  = blink_q;
  assign tick   = tick_q;
  assign chime  = chime_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a driver issues key/reset stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_clock_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 3;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [7:0] hour, minute, second;
  logic [1:0] mode;
  logic [2:0] blink;
  logic       tick, chime;

  clock_ctrl #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .CP(CP), .CR(CR), .key_mode(key_mode), .key_inc(key_inc),
    .hour(hour), .minute(minute), .second(second), .mode(mode),
    .blink(blink), .tick(tick), .chime(chime)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic [7:0] h, m, s;
    logic [1:0] md;
    logic [2:0] bl;
    logic       tk, ch;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: time held as plain integers, mode as 0..3.
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_div = 0, m_bc = 0, m_ph = 0;
  int m_pm = 0, m_pi = 0, m_tick = 0, m_chime = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model(input logic cr, input logic km, input logic ki);
    int me, ie, nbc, nph;
    if (cr) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_div = 0; m_bc = 0; m_ph = 0;
      m_tick = 0; m_chime = 0;
    end else begin
      me = (km && !m_pm) ? 1 : 0;
      ie = (ki && !m_pi) ? 1 : 0;
      m_tick  = (m_div == CLK_DIV - 1) ? 1 : 0;
      m_chime = 0;
      m_div   = m_tick ? 0 : m_div + 1;
      if (m_mode == 0 && m_tick) begin
        m_s++;
        if (m_s == 60) begin
          m_s = 0;
          m_m++;
          if (m_m == 60) begin
            m_m = 0;
            m_h = (m_h + 1) % 24;
            m_chime = 1;
          end
        end
      end
      if (m_bc == BLINK_DIV - 1) begin nbc = 0; nph = 1 - m_ph; end
      else begin nbc = m_bc + 1; nph = m_ph; end
      if (me) begin
        if (m_mode == 3) m_div = 0;
        m_mode = (m_mode + 1) % 4;
        if (m_mode != 0) begin nbc = 0; nph = 0; end
      end else if (ie && m_mode != 0) begin
        if (m_mode == 1) m_h = (m_h + 1) % 24;
        else if (m_mode == 2) m_m = (m_m + 1) % 60;
        else m_s = (m_s + 1) % 60;
        nbc = 0; nph = 0;
      end
      m_bc = nbc;
      m_ph = nph;
    end
    m_pm = km;
    m_pi = ki;
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.h  = bcd(m_h);
    e.m  = bcd(m_m);
    e.s  = bcd(m_s);
    e.md = 2'(m_mode);
    e.bl = (m_mode == 0) ? 3'b000 : 3'(m_ph << (3 - m_mode));
    e.tk = m_tick[0];
    e.ch = m_chime[0];
    return e;
  endfunction

  task automatic step(input logic cr, input logic km, input logic ki);
    @(negedge CP);
    CR = cr; key_mode = km; key_inc = ki;
    model(cr, km, ki);
    q.push_back(expected());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      for (int j = 0; j <= int'($urandom_range(0, 2)); j++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    press_mode(); press_inc(h);
    press_mode(); press_inc(m);
    press_mode(); press_inc(s);
    press_mode();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every presented output cycle against the queue head.
  always @(posedge CP) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("hour", hour, e.h);
      check("minute", minute, e.m);
      check("second", second, e.s);
      check("mode", {6'd0, mode}, {6'd0, e.md});
      check("blink", {5'd0, blink}, {5'd0, e.bl});
      check("tick", {7'd0, tick}, {7'd0, e.tk});
      check("chime", {7'd0, chime}, {7'd0, e.ch});
    end
  end

  initial begin
    // Reset and free-running ticks.
    do_reset(2);
    idle(13);
    // Set 23:59:59 and roll over to midnight.
    set_time(23, 59, 59);
    idle(12);
    // BCD carries in RUN.
    do_reset(1); set_time(0, 0, 9);   idle(6);
    do_reset(1); set_time(0, 9, 59);  idle(6);
    do_reset(1); set_time(9, 59, 59); idle(6);
    // SET_H blinking and full hour wrap.
    do_reset(1);
    press_mode();
    idle(10);
    press_inc(24);
    idle(8);
    // Simultaneous keys, then key_inc held across reset.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    // Reset mid-setting in SET_M.
    do_reset(1);
    press_mode(); press_mode();
    press_inc(37);
    do_reset(1);
    idle(10);
    // Randomized segment from a random start time.
    do_reset(1);
    set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    idle(2);
    repeat (3) @(negedge CP);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Timekeeping and time-setting controller for the digital clock display path. Generates a 1 s tick from CP and keeps BCD hour, minute and second registers. A mode state machine lets the user set each field with two debounced keys. Outputs feed the BCD display multiplexer directly, plus a per-field blink mask and an hourly chime pulse.

Parameters:
CLK_DIV, 50000000, CP cycles per second (tick period); must be >= 2
BLINK_DIV, 25000000, CP cycles per half blink period; must be >= 2

Ports:
CP  input  1  system clock; all state on rising edge
CR  input  1  synchronous active-high reset
key_mode  input  1  debounced mode key, level; rising edge acts
key_inc  input  1  debounced increment key, level; rising edge acts
hour  output  8  BCD hours 00-23, [7:4] tens, [3:0] units
minute  output  8  BCD minutes 00-59
second  output  8  BCD seconds 00-59
mode  output  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
blink  output  3  blank request, 1 = blank; [2] hour, [1] minute, [0] second
tick  output  1  one-cycle pulse per second
chime  output  1  one-cycle pulse on hour rollover in RUN

Behaviour:
- One clock, CP. Reset is synchronous and active-high on CR.
- Reset values at the CR edge:
  - hour, minute and second = 8'h00; mode = 00; blink = 000; tick = 0; chime = 0.
  - Divider and blink counters = 0; blink phase = 0.
  - Key history registers load the current key levels, so a key held through reset produces no edge.
- CR asserted mid-operation in any mode gives the same result: full reset at that edge.
- Edge detect: mode_edge = key_mode & ~prev_mode; inc_edge likewise. Each key's history register updates every cycle.
- Divider: counts 0..CLK_DIV-1 in every mode and wraps to 0.
  - At the edge where the count equals CLK_DIV-1, tick <= 1 for one cycle; otherwise tick <= 0.
  - The divider clears to 0 on the SET_S -> RUN transition, so the first second after setting is full length.
- Time advance happens only in RUN, at the same edge that raises tick. The new value is visible in the same cycle tick is high.
  - Units nibble: 9 -> 0 with a carry into tens.
  - second 8'h59 -> 8'h00 carries into minute; minute 8'h59 -> 8'h00 carries into hour.
  - hour 8'h23 -> 8'h00.
  - chime <= 1 at that edge only when minute and second both roll over (hh:59:59 -> hh+1:00:00).
- Mode FSM:
  - On mode_edge: RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - inc_edge in SET_H: hour + 1 BCD, 23 -> 00.
  - inc_edge in SET_M: minute + 1, 59 -> 00, no carry into hour.
  - inc_edge in SET_S: second + 1, 59 -> 00, no carry into minute.
  - inc_edge in RUN is ignored.
  - In SET modes, ticks do not advance time.
- Simultaneous mode_edge and inc_edge: the mode transition wins and the increment is dropped.
- Blink:
  - Counter runs 0..BLINK_DIV-1 and toggles the phase on wrap.
  - blink bit for the field being set = phase; other bits = 0; RUN gives blink = 000.
  - On any accepted inc_edge, or on entry to a SET mode, the counter clears and phase = 0, so the value is visible immediately.
- Registers are written only by this block, so illegal BCD codes cannot occur.
- All outputs are registered.

Test Plan:
1. CLK_DIV=4, BLINK_DIV=3. CR high 2 cycles, then release -> hour/minute/second 00, mode 00, blink 000. First tick in the 4th cycle after release, with second=8'h01; tick repeats every 4 cycles.
2. Set the time to 23:59:59 via SET_H (23 incs), SET_M (59), SET_S (59), then mode back to RUN. After 4 cycles: tick=1, chime=1 for one cycle, time = 00:00:00. Chime stays 0 on all other ticks.
3. BCD carry in RUN: 00:00:09 -> 00:00:10 (second=8'h10). 00:09:59 -> 00:10:00 with chime=0. 09:59:59 -> 10:00:00 with chime=1.
4. Enter SET_H -> mode 01, blink[2] toggles every 3 cycles, blink[1:0]=00. 24 inc edges -> hour returns to 8'h00. minute/second unchanged despite ticks. Each inc edge forces blink[2]=0.
5. In SET_H, key_mode and key_inc rise in the same cycle -> mode 10, hour unchanged. Hold key_inc high across a CR pulse, release CR -> no increment.
6. In SET_M with minute=8'h37, assert CR for one cycle -> all times 00, mode 00, blink 000, tick 0. Next tick arrives exactly 4 cycles later.
